lsu_arbiter: RTL and testbench

Shares the single load/store unit port between two requesters: port 0 is the core data path and port 1 is the debug/DMA loader. It performs valid/ready arbitration and drives one registered LSU access at a time. The load result returns on the granted port two cycles after acceptance. It sits between the pipeline MEM stage or loader and the lsu block.

---
 rtl/lsu_arb_pkg.sv | 20 ++
 rtl/lsu_arb_pick.sv | 55 +++++
 rtl/lsu_arbiter.sv | 128 ++++++++++++
 tb/tb_lsu_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-port LSU arbiter.
package lsu_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DBG  = 1'b1;

   localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/lsu_arb_pick.sv
// Port pick for the LSU arbiter: fixed priority with a saturating
// starvation counter that forces the secondary port through.
module lsu_arb_pick
   import lsu_arb_pkg::*;
#(
   parameter int unsigned P_PRIMARY      = 0,
   parameter int unsigned P_STARVE_LIMIT = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_accept,
   input  logic i_accept_port,
   output logic o_pick_valid,
   output logic o_pick_port
);

   localparam logic L_PRI = P_PRIMARY[0];
   localparam logic L_SEC = ~L_PRI;
   localparam logic [STARVE_CNT_W-1:0] L_LIMIT = P_STARVE_LIMIT[STARVE_CNT_W-1:0];
   localparam logic [STARVE_CNT_W-1:0] L_CNT_MAX = '1;

   logic [STARVE_CNT_W-1:0] r_cnt;
   logic [STARVE_CNT_W-1:0] w_cnt_next;
   logic                    w_pri_valid;
   logic                    w_sec_valid;
   logic                    w_force;

   assign w_pri_valid  = L_PRI ? i_valid1 : i_valid0;
   assign w_sec_valid  = L_PRI ? i_valid0 : i_valid1;
   assign w_force      = w_pri_valid & w_sec_valid & (r_cnt >= L_LIMIT);
   assign o_pick_valid = i_valid0 | i_valid1;
   assign o_pick_port  = (w_pri_valid & ~w_force) ? L_PRI : L_SEC;

   always_comb begin
      w_cnt_next = r_cnt;
      if (!w_sec_valid) begin
         w_cnt_next = '0;
      end else if (i_accept && (i_accept_port == L_SEC)) begin
         w_cnt_next = '0;
      end else if (i_accept && (r_cnt != L_CNT_MAX)) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-port valid/ready arbiter in front of the single LSU port: one registered
// access at a time, load data returned on the granted port two cycles later.
module lsu_arbiter
   import lsu_arb_pkg::*;
#(
   parameter int unsigned P_PRIMARY      = 0,
   parameter int unsigned P_STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [31:0] i_req0_addr,
   input  logic [31:0] i_req0_wdata,
   input  logic        i_req0_wren,
   input  logic [2:0]  i_req0_type,
   output logic        o_rsp0_valid,
   output logic [31:0] o_rsp0_rdata,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [31:0] i_req1_addr,
   input  logic [31:0] i_req1_wdata,
   input  logic        i_req1_wren,
   input  logic [2:0]  i_req1_type,
   output logic        o_rsp1_valid,
   output logic [31:0] o_rsp1_rdata,
   output logic [31:0] o_lsu_addr,
   output logic [31:0] o_st_data,
   output logic        o_lsu_wren,
   output logic [2:0]  o_type_access,
   input  logic [31:0] i_ld_data,
   output logic        o_busy
);

   state_e      r_state;
   state_e      w_state_next;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_wren;
   logic [2:0]  r_type;
   logic        r_port;
   logic [31:0] r_rsp0_rdata;
   logic [31:0] r_rsp1_rdata;
   logic        w_pick_valid;
   logic        w_pick_port;
   logic        w_can_accept;
   logic        w_accept;

   lsu_arb_pick #(
      .P_PRIMARY      (P_PRIMARY),
      .P_STARVE_LIMIT (P_STARVE_LIMIT)
   ) u_pick (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_valid0      (i_req0_valid),
      .i_valid1      (i_req1_valid),
      .i_accept      (w_accept),
      .i_accept_port (w_pick_port),
      .o_pick_valid  (w_pick_valid),
      .o_pick_port   (w_pick_port)
   );

   // Reset gates ready so nothing is handshaken while the block is held in reset.
   assign w_can_accept = i_reset & ((r_state == IDLE) | (r_state == RESP));
   assign w_accept     = w_can_accept & w_pick_valid;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    w_state_next = w_accept ? ISSUE : IDLE;
         ISSUE:   w_state_next = RESP;
         RESP:    w_state_next = w_accept ? ISSUE : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      o_req0_ready = w_accept & i_req0_valid & (w_pick_port == PORT_CORE);
      o_req1_ready = w_accept & i_req1_valid & (w_pick_port == PORT_DBG);
      o_rsp0_valid = (r_state == RESP) & (r_port == PORT_CORE);
      o_rsp1_valid = (r_state == RESP) & (r_port == PORT_DBG);
      o_lsu_wren   = (r_state == ISSUE) & r_wren;
      o_busy       = (r_state != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wren       <= 1'b0;
         r_type       <= '0;
         r_port       <= PORT_CORE;
         r_rsp0_rdata <= '0;
         r_rsp1_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= w_pick_port ? i_req1_addr  : i_req0_addr;
            r_wdata <= w_pick_port ? i_req1_wdata : i_req0_wdata;
            r_wren  <= w_pick_port ? i_req1_wren  : i_req0_wren;
            r_type  <= w_pick_port ? i_req1_type  : i_req0_type;
            r_port  <= w_pick_port;
         end
         // Only the served port's rdata moves; the other keeps its last response.
         if (r_state == ISSUE) begin
            if (r_port == PORT_CORE) begin
               r_rsp0_rdata <= r_wren ? 32'h0 : i_ld_data;
            end else begin
               r_rsp1_rdata <= r_wren ? 32'h0 : i_ld_data;
            end
         end
      end
   end

   assign o_lsu_addr    = r_addr;
   assign o_st_data     = r_wdata;
   assign o_type_access = r_type;
   assign o_rsp0_rdata  = r_rsp0_rdata;
   assign o_rsp1_rdata  = r_rsp1_rdata;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter with a small combinational memory / LED model.
module tb_lsu_arbiter;
   import lsu_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] a0 = '0, a1 = '0, wd0 = '0, wd1 = '0;
   logic [2:0]  t0 = '0, t1 = '0;
   logic        rdy0, rdy1, rsp0v, rsp1v, lsu_wren, busy;
   logic [31:0] rsp0d, rsp1d, lsu_addr, st_data, ld_data;
   logic [2:0]  type_access;
   logic [31:0] ledr = '0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   lsu_arbiter #(
      .P_PRIMARY      (0),
      .P_STARVE_LIMIT (4)
   ) u_dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_req0_valid  (v0),
      .o_req0_ready  (rdy0),
      .i_req0_addr   (a0),
      .i_req0_wdata  (wd0),
      .i_req0_wren   (we0),
      .i_req0_type   (t0),
      .o_rsp0_valid  (rsp0v),
      .o_rsp0_rdata  (rsp0d),
      .i_req1_valid  (v1),
      .o_req1_ready  (rdy1),
      .i_req1_addr   (a1),
      .i_req1_wdata  (wd1),
      .i_req1_wren   (we1),
      .i_req1_type   (t1),
      .o_rsp1_valid  (rsp1v),
      .o_rsp1_rdata  (rsp1d),
      .o_lsu_addr    (lsu_addr),
      .o_st_data     (st_data),
      .o_lsu_wren    (lsu_wren),
      .o_type_access (type_access),
      .i_ld_data     (ld_data),
      .o_busy        (busy)
   );

   // Read-only memory image; 0x1000_0000 is the LED register written by stores.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (addr == 32'h0000_0010) return 32'hDEAD_BEEF;
      return {16'hA5A5, addr[15:0]};
   endfunction

   always_comb ld_data = (lsu_addr == 32'h1000_0000) ? ledr : mem_word(lsu_addr);

   always @(posedge clk) if (lsu_wren) ledr <= st_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v0, v1;
      logic        r0, r1, s0, s1, busy;
      logic [31:0] addr;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(input logic iv0, input logic iv1, input logic r0, input logic r1,
                               input logic s0, input logic s1, input logic b,
                               input logic [31:0] ad);
      vec_t v;
      v.v0 = iv0; v.v1 = iv1; v.r0 = r0; v.r1 = r1;
      v.s0 = s0; v.s1 = s1; v.busy = b; v.addr = ad;
      return v;
   endfunction

   initial begin
      // Both ports hold loads; expected grant order 0,0,0,0,1,0,0,0,0,1.
      vecs[0]  = mk(1, 1, 1, 0, 0, 0, 0, 32'h0);
      vecs[1]  = mk(1, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[2]  = mk(1, 1, 1, 0, 1, 0, 1, 32'h20);
      vecs[3]  = mk(1, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[4]  = mk(1, 1, 1, 0, 1, 0, 1, 32'h20);
      vecs[5]  = mk(1, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[6]  = mk(1, 1, 1, 0, 1, 0, 1, 32'h20);
      vecs[7]  = mk(1, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[8]  = mk(1, 1, 0, 1, 1, 0, 1, 32'h20);
      vecs[9]  = mk(1, 1, 0, 0, 0, 0, 1, 32'h30);
      vecs[10] = mk(1, 1, 1, 0, 0, 1, 1, 32'h30);
      vecs[11] = mk(1, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[12] = mk(1, 1, 1, 0, 1, 0, 1, 32'h20);
      vecs[13] = mk(1, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[14] = mk(1, 1, 1, 0, 1, 0, 1, 32'h20);
      vecs[15] = mk(1, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[16] = mk(1, 1, 1, 0, 1, 0, 1, 32'h20);
      vecs[17] = mk(1, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[18] = mk(1, 1, 0, 1, 1, 0, 1, 32'h20);
      vecs[19] = mk(1, 1, 0, 0, 0, 0, 1, 32'h30);
      vecs[20] = mk(0, 0, 0, 0, 0, 1, 1, 32'h30);
      vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0);

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_addr", lsu_addr, 0);
      chk("rst_wren", lsu_wren, 0);
      chk("rst_rsp0", rsp0v, 0);
      chk("rst_rdata1", rsp1d, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // 1: port 0 LW from 0x10
      v0 = 1; a0 = 32'h10; we0 = 0; t0 = LW;
      #1;
      chk("t1_rdy0", rdy0, 1);
      chk("t1_rdy1", rdy1, 0);
      tick();
      v0 = 0;
      chk("t1_addr", lsu_addr, 32'h10);
      chk("t1_wren", lsu_wren, 0);
      chk("t1_type", type_access, LW);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_rsp0v", rsp0v, 1);
      chk("t1_rdata", rsp0d, 32'hDEAD_BEEF);
      chk("t1_rsp1v", rsp1v, 0);
      tick();
      chk("t1_idle", busy, 0);
      chk("t1_rsp0_end", rsp0v, 0);

      // 2: port 1 SW to the LED register
      v1 = 1; a1 = 32'h1000_0000; wd1 = 32'hFF; we1 = 1; t1 = SW;
      #1;
      chk("t2_rdy1", rdy1, 1);
      tick();
      v1 = 0;
      chk("t2_wren", lsu_wren, 1);
      chk("t2_type", type_access, SW);
      chk("t2_stdata", st_data, 32'hFF);
      tick();
      chk("t2_wren_off", lsu_wren, 0);
      chk("t2_rsp1v", rsp1v, 1);
      chk("t2_rdata1", rsp1d, 0);
      chk("t2_rsp0v", rsp0v, 0);
      chk("t2_rdata0_hold", rsp0d, 32'hDEAD_BEEF);
      chk("t2_ledr", ledr, 32'hFF);
      tick();
      we1 = 0; t1 = LW;

      // 4: back-to-back port 0 loads
      v0 = 1; a0 = 32'h20; t0 = LW;
      #1;
      chk("t4_rdy_a", rdy0, 1);
      tick();
      a0 = 32'h24;
      #1;
      chk("t4_issue_nordy", rdy0, 0);
      tick();
      chk("t4_rsp_a", rsp0v, 1);
      chk("t4_rdata_a", rsp0d, 32'hA5A5_0020);
      chk("t4_rdy_b", rdy0, 1);
      tick();
      v0 = 0;
      chk("t4_addr_b", lsu_addr, 32'h24);
      chk("t4_gap", rsp0v, 0);
      tick();
      chk("t4_rsp_b", rsp0v, 1);
      chk("t4_rdata_b", rsp0d, 32'hA5A5_0024);
      tick();

      // 3: starvation table
      a0 = 32'h20; a1 = 32'h30; we0 = 0; we1 = 0; t0 = LW; t1 = LW;
      for (int i = 0; i < 22; i++) begin
         v0 = vecs[i].v0;
         v1 = vecs[i].v1;
         #1;
         chk($sformatf("t3_rdy0[%0d]", i), rdy0, vecs[i].r0);
         chk($sformatf("t3_rdy1[%0d]", i), rdy1, vecs[i].r1);
         chk($sformatf("t3_rsp0[%0d]", i), rsp0v, vecs[i].s0);
         chk($sformatf("t3_rsp1[%0d]", i), rsp1v, vecs[i].s1);
         chk($sformatf("t3_busy[%0d]", i), busy, vecs[i].busy);
         if (vecs[i].busy) chk($sformatf("t3_addr[%0d]", i), lsu_addr, vecs[i].addr);
         if (vecs[i].s0) chk($sformatf("t3_rd0[%0d]", i), rsp0d, 32'hA5A5_0020);
         if (vecs[i].s1) chk($sformatf("t3_rd1[%0d]", i), rsp1d, 32'hA5A5_0030);
         tick();
      end

      // 6: port 1 withdraws while port 0 holds priority
      v0 = 1; a0 = 32'h60; v1 = 1; a1 = 32'h70;
      #1;
      chk("t6_rdy0", rdy0, 1);
      chk("t6_rdy1", rdy1, 0);
      tick();
      chk("t6_cnt1", u_dut.u_pick.r_cnt, 1);
      tick();
      chk("t6_rdy0_b", rdy0, 1);
      chk("t6_rdy1_b", rdy1, 0);
      tick();
      v1 = 0;
      chk("t6_cnt2", u_dut.u_pick.r_cnt, 2);
      tick();
      v0 = 0;
      #1;
      chk("t6_cnt0", u_dut.u_pick.r_cnt, 0);
      chk("t6_rsp1v", rsp1v, 0);
      chk("t6_rdy1_c", rdy1, 0);
      tick();
      chk("t6_addr", lsu_addr, 32'h60);
      chk("t6_idle", busy, 0);

      // 5: reset during ISSUE of a store
      v0 = 1; a0 = 32'h40; wd0 = 32'h55; we0 = 1; t0 = SB;
      #1;
      chk("t5_rdy0", rdy0, 1);
      tick();
      v0 = 0;
      chk("t5_wren", lsu_wren, 1);
      rst_n = 1'b0;
      v0 = 1; a0 = 32'h30; we0 = 0; t0 = LW;
      #1;
      chk("t5_wren_rst", lsu_wren, 0);
      chk("t5_busy_rst", busy, 0);
      chk("t5_addr_rst", lsu_addr, 0);
      chk("t5_st_rst", st_data, 0);
      chk("t5_type_rst", type_access, 0);
      chk("t5_rdy_rst", rdy0, 0);
      chk("t5_rd0_rst", rsp0d, 0);
      chk("t5_rd1_rst", rsp1d, 0);
      tick();
      chk("t5_norsp", rsp0v, 0);
      chk("t5_ledr", ledr, 32'hFF);
      rst_n = 1'b1;
      #1;
      chk("t5_rdy_after", rdy0, 1);
      tick();
      v0 = 0;
      chk("t5_addr_after", lsu_addr, 32'h30);
      tick();
      chk("t5_rsp_after", rsp0v, 1);
      chk("t5_rd_after", rsp0d, 32'hA5A5_0030);
      tick();
      chk("t5_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
